// File: rtl/intersection_phase_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler_pkg
// Shared types and helpers for the two-approach intersection scheduler:
//   - phase_t  : state encodings (also driven out on the phase port)
//   - lamps_t  : one bit per lamp driver
//   - dur_m1   : duration in seconds -> counter load value (duration - 1)
//   - dur_ok   : legality of a duration for a given counter width
//   - lamp_decode : state -> lamp pattern
// -----------------------------------------------------------------------------
package intersection_phase_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_MAIN_GREEN  = 3'd1,
      ST_MAIN_YELLOW = 3'd2,
      ST_ALL_RED_1   = 3'd3,
      ST_PED_WALK    = 3'd4,
      ST_SIDE_GREEN  = 3'd5,
      ST_SIDE_YELLOW = 3'd6,
      ST_ALL_RED_2   = 3'd7
   } phase_t;

   typedef struct packed {
      logic main_red;
      logic main_yellow;
      logic main_green;
      logic side_red;
      logic side_yellow;
      logic side_green;
      logic walk;
   } lamps_t;

   // Default timing set
   localparam int unsigned DEF_MAIN_GREEN_SEC = 15;
   localparam int unsigned DEF_SIDE_GREEN_SEC = 10;
   localparam int unsigned DEF_YELLOW_SEC     = 3;
   localparam int unsigned DEF_ALL_RED_SEC    = 1;
   localparam int unsigned DEF_WALK_SEC       = 8;
   localparam int unsigned DEF_COUNT_WIDTH    = 5;

   // The counter holds "seconds remaining minus one", so a phase of N
   // seconds loads N-1 and expires on the tick seen while at zero.
   function automatic int unsigned dur_m1(input int unsigned dur);
      return dur - 32'd1;
   endfunction

   // A duration of 2^width still fits because only dur-1 is stored.
   function automatic bit dur_ok(input int unsigned dur, input int unsigned width);
      return (dur >= 32'd1) && (dur <= (32'd1 << width));
   endfunction

   function automatic lamps_t lamp_decode(input phase_t st);
      lamps_t l;
      l.main_green  = (st == ST_MAIN_GREEN);
      l.main_yellow = (st == ST_MAIN_YELLOW);
      l.main_red    = !((st == ST_MAIN_GREEN) || (st == ST_MAIN_YELLOW));
      l.side_green  = (st == ST_SIDE_GREEN);
      l.side_yellow = (st == ST_SIDE_YELLOW);
      l.side_red    = !((st == ST_SIDE_GREEN) || (st == ST_SIDE_YELLOW));
      l.walk        = (st == ST_PED_WALK);
      return l;
   endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler_if
// Control inputs and lamp/status outputs of the intersection scheduler.
//   master : the controlling side (drives en/sec_tick/requests, reads status)
//   slave  : the scheduler itself
// Signals:
//   en, sec_tick, side_req, ped_req               -> scheduler
//   main_*/side_* lamps, walk, remain, phase,
//   side_pending, ped_pending                     <- scheduler
// -----------------------------------------------------------------------------
interface intersection_phase_scheduler_if #(
   parameter int pCount_width = 5
);
   logic                    en;
   logic                    sec_tick;
   logic                    side_req;
   logic                    ped_req;
   logic                    main_red;
   logic                    main_yellow;
   logic                    main_green;
   logic                    side_red;
   logic                    side_yellow;
   logic                    side_green;
   logic                    walk;
   logic [pCount_width-1:0] remain;
   logic [2:0]              phase;
   logic                    side_pending;
   logic                    ped_pending;

   modport master (
      output en, sec_tick, side_req, ped_req,
      input  main_red, main_yellow, main_green,
      input  side_red, side_yellow, side_green, walk,
      input  remain, phase, side_pending, ped_pending
   );

   modport slave (
      input  en, sec_tick, side_req, ped_req,
      output main_red, main_yellow, main_green,
      output side_red, side_yellow, side_green, walk,
      output remain, phase, side_pending, ped_pending
   );
endinterface

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
// Seconds down-counter for one phase.
// Ports:
//   clk, rstb   clock, asynchronous active-low reset (count -> 0)
//   load        load load_val this clk (wins over dec)
//   load_val    value to load (phase duration - 1)
//   dec         one-second advance (en & sec_tick)
//   count       current count
//   zero        count == 0
// -----------------------------------------------------------------------------
module phase_timer #(
   parameter int pCount_width = 5
) (
   input  logic                    clk,
   input  logic                    rstb,
   input  logic                    load,
   input  logic [pCount_width-1:0] load_val,
   input  logic                    dec,
   output logic [pCount_width-1:0] count,
   output logic                    zero
);
   logic [pCount_width-1:0] count_reg;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec && (count_reg != '0)) begin
         // Saturates at zero: a held phase keeps showing 0
         count_reg <= count_reg - 1'b1;
      end
   end

   assign count = count_reg;
   assign zero  = (count_reg == '0);
endmodule

// File: rtl/intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler
// Main/side/pedestrian phase sequencer for a two-road junction. Main street
// rests in green; side and pedestrian demand is latched and served in the
// order MAIN_YELLOW -> ALL_RED_1 -> [PED_WALK] -> [SIDE_GREEN -> SIDE_YELLOW
// -> ALL_RED_2] -> MAIN_GREEN.
// Ports:
//   clk    system clock
//   rstb   asynchronous active-low reset
//   bus    intersection_phase_scheduler_if.slave (en, sec_tick, requests in;
//          lamps, remain, phase, pending flags out)
// -----------------------------------------------------------------------------
module intersection_phase_scheduler
   import intersection_phase_scheduler_pkg::*;
#(
   parameter int pMainGreen_Sec = DEF_MAIN_GREEN_SEC,
   parameter int pSideGreen_Sec = DEF_SIDE_GREEN_SEC,
   parameter int pYellow_Sec    = DEF_YELLOW_SEC,
   parameter int pAllRed_Sec    = DEF_ALL_RED_SEC,
   parameter int pWalk_Sec      = DEF_WALK_SEC,
   parameter int pCount_width   = DEF_COUNT_WIDTH
) (
   input  logic                          clk,
   input  logic                          rstb,
   intersection_phase_scheduler_if.slave bus
);
   localparam int NUM_DUR = 5;
   localparam int unsigned DURS [NUM_DUR] = '{pMainGreen_Sec, pSideGreen_Sec,
                                              pYellow_Sec, pAllRed_Sec, pWalk_Sec};

   // Elaboration-time guard on every duration
   for (genvar gi = 0; gi < NUM_DUR; gi++) begin : g_dur_check
      if (!dur_ok(DURS[gi], pCount_width)) begin : g_bad
         $error("duration index %0d out of range for counter width", gi);
      end
   end

   localparam logic [pCount_width-1:0] MAIN_GREEN_LD = pCount_width'(dur_m1(pMainGreen_Sec));
   localparam logic [pCount_width-1:0] SIDE_GREEN_LD = pCount_width'(dur_m1(pSideGreen_Sec));
   localparam logic [pCount_width-1:0] YELLOW_LD     = pCount_width'(dur_m1(pYellow_Sec));
   localparam logic [pCount_width-1:0] ALL_RED_LD    = pCount_width'(dur_m1(pAllRed_Sec));
   localparam logic [pCount_width-1:0] WALK_LD       = pCount_width'(dur_m1(pWalk_Sec));

   phase_t                  state_reg;
   phase_t                  state_next;
   lamps_t                  lamps_reg;
   logic                    side_pending_reg;
   logic                    ped_pending_reg;
   logic                    tick_en;
   logic                    expire;
   logic                    timer_load;
   logic [pCount_width-1:0] timer_load_val;
   logic [pCount_width-1:0] timer_count;
   logic                    timer_zero;

   assign tick_en = bus.en & bus.sec_tick;
   assign expire  = tick_en & timer_zero;

   // Next-state decode
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:        if (bus.en) state_next = ST_MAIN_GREEN;
         // Main green holds at zero until demand appears; the next expire
         // after that leaves.
         ST_MAIN_GREEN:  if (expire && (side_pending_reg || ped_pending_reg))
                            state_next = ST_MAIN_YELLOW;
         ST_MAIN_YELLOW: if (expire) state_next = ST_ALL_RED_1;
         ST_ALL_RED_1:   if (expire) state_next = ped_pending_reg ? ST_PED_WALK : ST_SIDE_GREEN;
         ST_PED_WALK:    if (expire) state_next = side_pending_reg ? ST_SIDE_GREEN : ST_MAIN_GREEN;
         ST_SIDE_GREEN:  if (expire) state_next = ST_SIDE_YELLOW;
         ST_SIDE_YELLOW: if (expire) state_next = ST_ALL_RED_2;
         ST_ALL_RED_2:   if (expire) state_next = ST_MAIN_GREEN;
         default:        state_next = ST_IDLE;
      endcase
   end

   // Every state change reloads the timer with the new phase's duration - 1
   always_comb begin
      timer_load     = (state_next != state_reg);
      timer_load_val = '0;
      case (state_next)
         ST_MAIN_GREEN:  timer_load_val = MAIN_GREEN_LD;
         ST_MAIN_YELLOW: timer_load_val = YELLOW_LD;
         ST_ALL_RED_1:   timer_load_val = ALL_RED_LD;
         ST_PED_WALK:    timer_load_val = WALK_LD;
         ST_SIDE_GREEN:  timer_load_val = SIDE_GREEN_LD;
         ST_SIDE_YELLOW: timer_load_val = YELLOW_LD;
         ST_ALL_RED_2:   timer_load_val = ALL_RED_LD;
         default:        timer_load_val = '0;
      endcase
   end

   phase_timer #(
      .pCount_width (pCount_width)
   ) u_phase_timer (
      .clk      (clk),
      .rstb     (rstb),
      .load     (timer_load),
      .load_val (timer_load_val),
      .dec      (tick_en),
      .count    (timer_count),
      .zero     (timer_zero)
   );

   // State, lamp registers and demand latches. Lamps are registered from
   // state_next so they always match state_reg with no input-to-output path.
   // Demand latches run regardless of en; clear on phase entry beats set.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_reg        <= ST_IDLE;
         lamps_reg        <= lamp_decode(ST_IDLE);
         side_pending_reg <= 1'b0;
         ped_pending_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         lamps_reg <= lamp_decode(state_next);

         if ((state_next == ST_SIDE_GREEN) && (state_reg != ST_SIDE_GREEN))
            side_pending_reg <= 1'b0;
         else if (bus.side_req && (state_reg != ST_SIDE_GREEN))
            side_pending_reg <= 1'b1;

         if ((state_next == ST_PED_WALK) && (state_reg != ST_PED_WALK))
            ped_pending_reg <= 1'b0;
         else if (bus.ped_req && (state_reg != ST_PED_WALK))
            ped_pending_reg <= 1'b1;
      end
   end

   assign bus.main_red     = lamps_reg.main_red;
   assign bus.main_yellow  = lamps_reg.main_yellow;
   assign bus.main_green   = lamps_reg.main_green;
   assign bus.side_red     = lamps_reg.side_red;
   assign bus.side_yellow  = lamps_reg.side_yellow;
   assign bus.side_green   = lamps_reg.side_green;
   assign bus.walk         = lamps_reg.walk;
   assign bus.remain       = timer_count;
   assign bus.phase        = state_reg;
   assign bus.side_pending = side_pending_reg;
   assign bus.ped_pending  = ped_pending_reg;
endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_phase_scheduler
// Directed bench for intersection_phase_scheduler with hand-computed
// expected values (default timing 15/10/3/1/8 s).
// -----------------------------------------------------------------------------
module tb_intersection_phase_scheduler;
   logic clk;
   logic rstb;
   int   n_checks;
   int   n_fails;

   intersection_phase_scheduler_if #(.pCount_width(5)) bus ();

   intersection_phase_scheduler dut (
      .clk  (clk),
      .rstb (rstb),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end else begin
         $display("ok   %s: %0d", tag, obs);
      end
   endtask

   // One sec_tick pulse per iteration; returns on the negedge after the
   // posedge that consumed it.
   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk) bus.sec_tick = 1'b1;
         @(negedge clk) bus.sec_tick = 1'b0;
      end
   endtask

   task automatic pulse_req(input bit side, input bit ped);
      @(negedge clk);
      bus.side_req = side;
      bus.ped_req  = ped;
      @(negedge clk);
      bus.side_req = 1'b0;
      bus.ped_req  = 1'b0;
   endtask

   task automatic restart();
      @(negedge clk) rstb = 1'b0;
      @(negedge clk) rstb = 1'b1;
      @(negedge clk);
      check_eq("restart_phase", bus.phase, 1);
      check_eq("restart_remain", bus.remain, 14);
   endtask

   // Bound on total run time
   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks     = 0;
      n_fails      = 0;
      rstb         = 1'b0;
      bus.en       = 1'b0;
      bus.sec_tick = 1'b0;
      bus.side_req = 1'b0;
      bus.ped_req  = 1'b0;

      // ---- Reset / start ----
      repeat (2) @(negedge clk);
      check_eq("rst_phase", bus.phase, 0);
      check_eq("rst_remain", bus.remain, 0);
      check_eq("rst_main_red", bus.main_red, 1);
      check_eq("rst_side_red", bus.side_red, 1);
      check_eq("rst_main_green", bus.main_green, 0);
      check_eq("rst_walk", bus.walk, 0);
      check_eq("rst_side_pend", bus.side_pending, 0);
      rstb = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("idle_en0_phase", bus.phase, 0);
      bus.en = 1'b1;
      @(negedge clk);
      check_eq("start_phase", bus.phase, 1);
      check_eq("start_main_green", bus.main_green, 1);
      check_eq("start_remain", bus.remain, 14);
      check_eq("start_side_red", bus.side_red, 1);

      // ---- No demand: 40 ticks, counter saturates at 0 ----
      for (int k = 1; k <= 40; k++) begin
         tick_n(1);
         check_eq($sformatf("nodem_remain_%0d", k), bus.remain, (k < 14) ? 14 - k : 0);
         check_eq($sformatf("nodem_side_red_%0d", k), bus.side_red, 1);
      end
      check_eq("nodem_phase", bus.phase, 1);
      // Demand arriving while held leaves on the next expire
      pulse_req(1'b1, 1'b0);
      check_eq("held_phase_before", bus.phase, 1);
      tick_n(1);
      check_eq("held_exit_phase", bus.phase, 2);
      check_eq("held_exit_remain", bus.remain, 2);

      // ---- Side service ----
      restart();
      tick_n(4);
      pulse_req(1'b1, 1'b0);
      check_eq("side_pend_set", bus.side_pending, 1);
      tick_n(10);
      check_eq("side_t14_phase", bus.phase, 1);
      check_eq("side_t14_remain", bus.remain, 0);
      tick_n(1);
      check_eq("side_t15_phase", bus.phase, 2);
      check_eq("side_t15_remain", bus.remain, 2);
      check_eq("side_t15_main_yel", bus.main_yellow, 1);
      tick_n(3);
      check_eq("side_ar1_phase", bus.phase, 3);
      check_eq("side_ar1_remain", bus.remain, 0);
      check_eq("side_ar1_main_red", bus.main_red, 1);
      tick_n(1);
      check_eq("side_sg_phase", bus.phase, 5);
      check_eq("side_sg_remain", bus.remain, 9);
      check_eq("side_sg_pend", bus.side_pending, 0);
      check_eq("side_sg_green", bus.side_green, 1);
      check_eq("side_sg_main_red", bus.main_red, 1);
      tick_n(10);
      check_eq("side_sy_phase", bus.phase, 6);
      check_eq("side_sy_yellow", bus.side_yellow, 1);
      tick_n(3);
      check_eq("side_ar2_phase", bus.phase, 7);
      tick_n(1);
      check_eq("side_back_phase", bus.phase, 1);
      check_eq("side_back_remain", bus.remain, 14);

      // ---- Ped plus side ----
      pulse_req(1'b1, 1'b1);
      check_eq("ps_side_pend", bus.side_pending, 1);
      check_eq("ps_ped_pend", bus.ped_pending, 1);
      tick_n(15);
      check_eq("ps_my_phase", bus.phase, 2);
      tick_n(3);
      check_eq("ps_ar1_phase", bus.phase, 3);
      tick_n(1);
      check_eq("ps_walk_phase", bus.phase, 4);
      check_eq("ps_walk_lamp", bus.walk, 1);
      check_eq("ps_walk_remain", bus.remain, 7);
      check_eq("ps_walk_ped_pend", bus.ped_pending, 0);
      check_eq("ps_walk_side_pend", bus.side_pending, 1);
      check_eq("ps_walk_main_red", bus.main_red, 1);
      check_eq("ps_walk_side_red", bus.side_red, 1);
      tick_n(7);
      check_eq("ps_walk_end_phase", bus.phase, 4);
      check_eq("ps_walk_end_lamp", bus.walk, 1);
      tick_n(1);
      check_eq("ps_sg_phase", bus.phase, 5);
      check_eq("ps_sg_walk", bus.walk, 0);
      check_eq("ps_sg_side_pend", bus.side_pending, 0);
      check_eq("ps_sg_remain", bus.remain, 9);

      // ---- Freeze in SIDE_GREEN at remain=6 ----
      tick_n(3);
      check_eq("frz_pre_remain", bus.remain, 6);
      @(negedge clk) bus.en = 1'b0;
      tick_n(2);
      pulse_req(1'b0, 1'b1);
      tick_n(3);
      check_eq("frz_remain", bus.remain, 6);
      check_eq("frz_phase", bus.phase, 5);
      check_eq("frz_ped_pend", bus.ped_pending, 1);
      check_eq("frz_side_green", bus.side_green, 1);
      @(negedge clk) bus.en = 1'b1;
      tick_n(1);
      check_eq("frz_resume_remain", bus.remain, 5);
      tick_n(6);
      check_eq("frz_sy_phase", bus.phase, 6);
      check_eq("frz_sy_remain", bus.remain, 2);

      // ---- Mid-run asynchronous reset in SIDE_YELLOW ----
      pulse_req(1'b1, 1'b0);
      check_eq("mid_side_pend", bus.side_pending, 1);
      #2 rstb = 1'b0;
      #1;
      check_eq("mid_rst_phase", bus.phase, 0);
      check_eq("mid_rst_main_red", bus.main_red, 1);
      check_eq("mid_rst_side_red", bus.side_red, 1);
      check_eq("mid_rst_side_yel", bus.side_yellow, 0);
      check_eq("mid_rst_side_pend", bus.side_pending, 0);
      check_eq("mid_rst_ped_pend", bus.ped_pending, 0);
      check_eq("mid_rst_remain", bus.remain, 0);
      @(negedge clk) rstb = 1'b1;
      @(negedge clk);
      check_eq("mid_rel_phase", bus.phase, 1);
      check_eq("mid_rel_remain", bus.remain, 14);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
- Sequences a two-approach intersection: main street, side street, and an exclusive pedestrian walk phase.
- Main street rests in green. Side-street and pedestrian demand are latched and served in a fixed order.
- Contains its own seconds down-counter, advanced by the shared 1 Hz tick. Lamp outputs drive the lamp drivers directly.
- Sits one level above the single-approach light controller and replaces it for two-road junctions.

Parameters:
- pMainGreen_Sec, 15, minimum main green in seconds
- pSideGreen_Sec, 10, fixed side green in seconds
- pYellow_Sec, 3, yellow duration for both approaches
- pAllRed_Sec, 1, all-red clearance after each yellow
- pWalk_Sec, 8, pedestrian walk duration
- pCount_width, 5, width of the remaining-seconds counter; every duration must be in the range 1..2^pCount_width

Ports:
- clk  in  1  system clock
- rstb  in  1  asynchronous active-low reset
- en  in  1  run enable; 0 freezes state and counter
- sec_tick  in  1  one-clk pulse per second
- side_req  in  1  side-street vehicle sensor, level or pulse
- ped_req  in  1  pedestrian button, pulse
- main_red/main_yellow/main_green  out  1 each  main-street lamps
- side_red/side_yellow/side_green  out  1 each  side-street lamps
- walk  out  1  pedestrian walk lamp
- remain  out  pCount_width  seconds remaining in the current phase, minus 1
- phase  out  3  current state code
- side_pending/ped_pending  out  1 each  latched demand flags

Behaviour:
- Clock and reset: single clock clk; reset rstb is asynchronous and active-low.
- Reset values:
  - phase=IDLE(0), remain=0, side_pending=0, ped_pending=0.
  - main_red=side_red=1; all other lamps=0; walk=0.
- State codes: IDLE 0, MAIN_GREEN 1, MAIN_YELLOW 2, ALL_RED_1 3, PED_WALK 4, SIDE_GREEN 5, SIDE_YELLOW 6, ALL_RED_2 7.
- Expire condition: expire = en & sec_tick & (remain==0).
- Counter:
  - On every state change, remain loads (new state's duration − 1).
  - Otherwise, remain decrements on en & sec_tick when remain≠0.
  - When a load and a decrement coincide, the load wins.
  - remain never wraps below 0.
- Transitions (all gated by en):
  - IDLE → MAIN_GREEN on the first clk with en=1, independent of sec_tick.
  - MAIN_GREEN: on expire, go to MAIN_YELLOW if side_pending|ped_pending. Otherwise hold, with remain held at 0. Any later expire with demand present leaves the state.
  - MAIN_YELLOW → ALL_RED_1 on expire.
  - ALL_RED_1 on expire: go to PED_WALK if ped_pending, else SIDE_GREEN.
  - PED_WALK on expire: go to SIDE_GREEN if side_pending, else MAIN_GREEN.
  - SIDE_GREEN → SIDE_YELLOW on expire. No extension.
  - SIDE_YELLOW → ALL_RED_2 → MAIN_GREEN, each on expire.
- Demand latches:
  - side_pending sets on side_req=1 in any state except SIDE_GREEN. It clears on the clk that enters SIDE_GREEN; clear wins over a simultaneous set.
  - ped_pending sets on ped_req=1 in any state except PED_WALK. It clears on entry to PED_WALK; clear wins.
  - Latches capture requests even while en=0. They do not capture during reset.
- Lamp decode: outputs are decoded from the registered state only, with no combinational path from inputs.
  - main_green in state 1; main_yellow in 2; main_red in all other states.
  - side_green in 5; side_yellow in 6; side_red in all other states.
  - walk in 4 only.
  - Exactly one lamp per approach is lit at all times.
- en=0: state, remain and lamps are held; sec_tick is ignored.
- Reset mid-operation: all outputs immediately return to their reset values, regardless of clk.

Decomposition:
- Shared package holds:
  - the state encodings above;
  - localparam durations-minus-1 computed at the parameter width;
  - a compile-time check that each duration is ≤ 2^pCount_width.
- Sub-module phase_timer:
  - ports: load, load_val, dec (= en & sec_tick), count, zero;
  - parameterized by pCount_width;
  - reused by the scheduler's FSM.

Test Plan:
- Reset/start:
  - Stimulus: rstb=0, then release with en=1.
  - Response: phase=0, both approaches red, remain=0 during reset. One clk after release: phase=1, main_green=1, remain=14.
- No demand:
  - Stimulus: 40 sec_ticks.
  - Response: phase stays 1. remain reaches 0 after 14 ticks and holds. side_red=1 throughout.
- Side service:
  - Stimulus: side_req pulse at tick 5.
  - Response:
    - tick 15: phase 2, remain=2;
    - +3 ticks: phase 3, remain=0;
    - +1 tick: phase 5, remain=9, side_pending=0;
    - +10 ticks: phase 6;
    - +3 ticks: phase 7;
    - +1 tick: phase 1, remain=14.
- Ped plus side:
  - Stimulus: ped_req and side_req asserted in the same clk during MAIN_GREEN.
  - Response: sequence 1→2→3→4 (walk=1 for 8 ticks, all vehicle lamps red) →5. ped_pending clears on entry to state 4.
- Freeze:
  - Stimulus: en=0 for 5 sec_ticks in SIDE_GREEN at remain=6, with ped_req pulsed meanwhile.
  - Response: remain stays 6, phase stays 5, ped_pending=1. On en=1, counting resumes from 6.
- Mid-run reset:
  - Stimulus: rstb=0 during SIDE_YELLOW with side_pending=1.
  - Response: phase=0 and both approaches red asynchronously, side_pending=0. After release, MAIN_GREEN with remain=14.
